// File: rtl/dma_wr_ctrl.sv
// PL-to-PS DMA write sequencer: writes num frames of len words with an idle gap between frames.
// Define DMA_WR_FRAME_TAG_EN to put the frame index in W_data_o[DATA_W-1:DATA_W-8] and the word index below it.
//   state | meaning
//   IDLE  | waiting for a start_i rising edge
//   ARM   | latch configuration, clear counters
//   WRITE | one word per cycle unless full or abort
//   GAP   | idle cycles between frames
//   DONE  | one-cycle end-of-transfer pulse
module dma_wr_ctrl #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16,
  parameter int FRM_W  = 8,
  parameter int GAP_W  = 8
) (
  input  logic              pl_clk,
  input  logic              dma_rstn,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [LEN_W-1:0]  xfer_len_i,
  input  logic [FRM_W-1:0]  frame_num_i,
  input  logic [GAP_W-1:0]  gap_i,
  input  logic              wr_full_i,
  output logic [DATA_W-1:0] W_data_o,
  output logic              W_wren_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              done_o,
  output logic [31:0]       xfer_words_o
);

  typedef enum logic [2:0] {IDLE, ARM, WRITE, GAP, DONE} state_t;

  state_t            state;
  logic              start_s0, start_s1;
  logic [LEN_W-1:0]  len_r, word_idx;
  logic [FRM_W-1:0]  num_r, frm_idx;
  logic [GAP_W-1:0]  gap_r, gap_cnt;
  logic [DATA_W-1:0] data_r, data_next;
  logic [31:0]       words_r;
  logic              start_rise, accept, last_word, last_frame;

  assign start_rise = start_s0 & ~start_s1;
  assign accept     = (state == WRITE) & ~wr_full_i & ~abort_i;
  assign last_word  = (word_idx == len_r - LEN_W'(1));
  // num = 0 means continuous, so no frame is ever the last one
  assign last_frame = (num_r != '0) && (frm_idx == num_r - FRM_W'(1));

`ifdef DMA_WR_FRAME_TAG_EN
  assign data_next = last_word ?
                     {8'(frm_idx + FRM_W'(1)), {(DATA_W-8){1'b0}}} :
                     {data_r[DATA_W-1:DATA_W-8], (DATA_W-8)'(word_idx + LEN_W'(1))};
`else
  assign data_next = data_r + DATA_W'(1);
`endif

  assign W_wren_o     = accept;
  assign frame_done_o = accept & last_word;
  assign busy_o       = (state != IDLE);
  assign done_o       = (state == DONE);
  assign W_data_o     = data_r;
  assign xfer_words_o = words_r;

  always_ff @(posedge pl_clk or negedge dma_rstn) begin
    if (!dma_rstn) begin
      state    <= IDLE;
      start_s0 <= 1'b0;
      start_s1 <= 1'b0;
      len_r    <= '0;
      num_r    <= '0;
      gap_r    <= '0;
      gap_cnt  <= '0;
      word_idx <= '0;
      frm_idx  <= '0;
      data_r   <= '0;
      words_r  <= '0;
    end else begin
      start_s0 <= start_i;
      start_s1 <= start_s0;
      case (state)
        IDLE: if (start_rise) state <= ARM;
        ARM: begin
          len_r    <= xfer_len_i;
          num_r    <= frame_num_i;
          gap_r    <= gap_i;
          data_r   <= '0;
          word_idx <= '0;
          frm_idx  <= '0;
          words_r  <= '0;
          if (abort_i || xfer_len_i == '0) state <= DONE;
          else                             state <= WRITE;
        end
        WRITE: begin
          if (abort_i) begin
            state <= DONE;
          end else if (accept) begin
            data_r  <= data_next;
            words_r <= words_r + 32'd1;
            if (last_word) begin
              word_idx <= '0;
              frm_idx  <= frm_idx + FRM_W'(1);
              if (last_frame) begin
                state <= DONE;
              end else if (gap_r != '0) begin
                gap_cnt <= gap_r - GAP_W'(1);
                state   <= GAP;
              end
            end else begin
              word_idx <= word_idx + LEN_W'(1);
            end
          end
        end
        GAP: begin
          if (abort_i)              state <= DONE;
          else if (gap_cnt == '0)   state <= WRITE;
          else                      gap_cnt <= gap_cnt - GAP_W'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_wr_ctrl.sv
// Directed bench for dma_wr_ctrl: per-cycle expected vectors for the write stream and status pulses.
module tb_dma_wr_ctrl;
  localparam int DATA_W = 32, LEN_W = 16, FRM_W = 8, GAP_W = 8;
  localparam logic [31:0] NOD = 32'hDEAD_BEEF;

  logic              pl_clk = 1'b0;
  logic              dma_rstn = 1'b0;
  logic              start_i = 1'b0, abort_i = 1'b0, wr_full_i = 1'b0;
  logic [LEN_W-1:0]  xfer_len_i = '0;
  logic [FRM_W-1:0]  frame_num_i = '0;
  logic [GAP_W-1:0]  gap_i = '0;
  logic [DATA_W-1:0] W_data_o;
  logic              W_wren_o, busy_o, frame_done_o, done_o;
  logic [31:0]       xfer_words_o;

  int    n_chk = 0, n_fail = 0, vec = 0;
  string tname = "rst";

  dma_wr_ctrl #(.DATA_W(DATA_W), .LEN_W(LEN_W), .FRM_W(FRM_W), .GAP_W(GAP_W)) dut (
    .pl_clk(pl_clk), .dma_rstn(dma_rstn), .start_i(start_i), .abort_i(abort_i),
    .xfer_len_i(xfer_len_i), .frame_num_i(frame_num_i), .gap_i(gap_i),
    .wr_full_i(wr_full_i), .W_data_o(W_data_o), .W_wren_o(W_wren_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .done_o(done_o),
    .xfer_words_o(xfer_words_o)
  );

  always #5 pl_clk = ~pl_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dv(input int frm, input int wrd, input int seq);
`ifdef DMA_WR_FRAME_TAG_EN
    return {8'(frm), 24'(wrd)};
`else
    return 32'(seq);
`endif
  endfunction

  // one clock cycle: drive full/abort after the edge, check outputs at the falling edge
  task automatic cyc(input logic full, input logic abort, input logic ew, input logic [31:0] ed,
                     input logic efd, input logic edn, input logic eb);
    @(posedge pl_clk); #2;
    wr_full_i = full;
    abort_i   = abort;
    @(negedge pl_clk);
    vec++;
    check_val($sformatf("%s.%0d wren", tname, vec), 32'(W_wren_o), 32'(ew));
    if (ed != NOD) check_val($sformatf("%s.%0d data", tname, vec), W_data_o, ed);
    check_val($sformatf("%s.%0d frame_done", tname, vec), 32'(frame_done_o), 32'(efd));
    check_val($sformatf("%s.%0d done", tname, vec), 32'(done_o), 32'(edn));
    check_val($sformatf("%s.%0d busy", tname, vec), 32'(busy_o), 32'(eb));
  endtask

  task automatic start_xfer(input string name, input int len, input int num, input int gap);
    tname = name;
    vec   = 0;
    @(posedge pl_clk); #2;
    xfer_len_i  = LEN_W'(len);
    frame_num_i = FRM_W'(num);
    gap_i       = GAP_W'(gap);
    start_i     = 1'b1;
    @(posedge pl_clk); #2;
    start_i = 1'b0;
  endtask

  initial begin
    #12;
    check_val("rst wren", 32'(W_wren_o), 32'd0);
    check_val("rst data", W_data_o, 32'd0);
    check_val("rst busy", 32'(busy_o), 32'd0);
    check_val("rst done", 32'(done_o), 32'd0);
    check_val("rst xfer_words", xfer_words_o, 32'd0);
    @(posedge pl_clk); #2;
    dma_rstn = 1'b1;

    // single frame, 4 words
    start_xfer("single", 4, 1, 0);
    cyc(0, 0, 0, NOD, 0, 0, 1);
    cyc(0, 0, 1, dv(0, 0, 0), 0, 0, 1);
    cyc(0, 0, 1, dv(0, 1, 1), 0, 0, 1);
    cyc(0, 0, 1, dv(0, 2, 2), 0, 0, 1);
    cyc(0, 0, 1, dv(0, 3, 3), 1, 0, 1);
    cyc(0, 0, 0, NOD, 0, 1, 1);
    cyc(0, 0, 0, NOD, 0, 0, 0);
    check_val("single xfer_words", xfer_words_o, 32'd4);

    // two frames of 3 with a 2-cycle gap
    start_xfer("gap", 3, 2, 2);
    cyc(0, 0, 0, NOD, 0, 0, 1);
    cyc(0, 0, 1, dv(0, 0, 0), 0, 0, 1);
    cyc(0, 0, 1, dv(0, 1, 1), 0, 0, 1);
    cyc(0, 0, 1, dv(0, 2, 2), 1, 0, 1);
    cyc(0, 0, 0, dv(1, 0, 3), 0, 0, 1);
    cyc(0, 0, 0, dv(1, 0, 3), 0, 0, 1);
    cyc(0, 0, 1, dv(1, 0, 3), 0, 0, 1);
    cyc(0, 0, 1, dv(1, 1, 4), 0, 0, 1);
    cyc(0, 0, 1, dv(1, 2, 5), 1, 0, 1);
    cyc(0, 0, 0, NOD, 0, 1, 1);
    cyc(0, 0, 0, NOD, 0, 0, 0);
    check_val("gap xfer_words", xfer_words_o, 32'd6);

    // 8 words, downstream full in frame cycles 3..5
    start_xfer("stall", 8, 1, 0);
    cyc(0, 0, 0, NOD, 0, 0, 1);
    cyc(0, 0, 1, dv(0, 0, 0), 0, 0, 1);
    cyc(0, 0, 1, dv(0, 1, 1), 0, 0, 1);
    cyc(1, 0, 0, dv(0, 2, 2), 0, 0, 1);
    cyc(1, 0, 0, dv(0, 2, 2), 0, 0, 1);
    cyc(1, 0, 0, dv(0, 2, 2), 0, 0, 1);
    cyc(0, 0, 1, dv(0, 2, 2), 0, 0, 1);
    cyc(0, 0, 1, dv(0, 3, 3), 0, 0, 1);
    cyc(0, 0, 1, dv(0, 4, 4), 0, 0, 1);
    cyc(0, 0, 1, dv(0, 5, 5), 0, 0, 1);
    cyc(0, 0, 1, dv(0, 6, 6), 0, 0, 1);
    cyc(0, 0, 1, dv(0, 7, 7), 1, 0, 1);
    cyc(0, 0, 0, NOD, 0, 1, 1);
    cyc(0, 0, 0, NOD, 0, 0, 0);
    check_val("stall xfer_words", xfer_words_o, 32'd8);

    // continuous mode, abort lands on a frame's last word
    start_xfer("abort", 2, 0, 0);
    cyc(0, 0, 0, NOD, 0, 0, 1);
    cyc(0, 0, 1, dv(0, 0, 0), 0, 0, 1);
    cyc(0, 0, 1, dv(0, 1, 1), 1, 0, 1);
    cyc(0, 0, 1, dv(1, 0, 2), 0, 0, 1);
    cyc(0, 0, 1, dv(1, 1, 3), 1, 0, 1);
    cyc(0, 0, 1, dv(2, 0, 4), 0, 0, 1);
    cyc(0, 0, 1, dv(2, 1, 5), 1, 0, 1);
    cyc(0, 0, 1, dv(3, 0, 6), 0, 0, 1);
    cyc(0, 1, 0, dv(3, 1, 7), 0, 0, 1);
    cyc(0, 0, 0, NOD, 0, 1, 1);
    cyc(0, 0, 0, NOD, 0, 0, 0);
    check_val("abort xfer_words", xfer_words_o, 32'd7);

    // zero length, plus a start edge while busy that must be ignored
    start_xfer("len0", 0, 1, 0);
    cyc(0, 0, 0, NOD, 0, 0, 1);
    start_i = 1'b1;
    cyc(0, 0, 0, NOD, 0, 1, 1);
    cyc(0, 0, 0, NOD, 0, 0, 0);
    cyc(0, 0, 0, NOD, 0, 0, 0);
    cyc(0, 0, 0, NOD, 0, 0, 0);
    start_i = 1'b0;
    cyc(0, 0, 0, NOD, 0, 0, 0);
    check_val("len0 xfer_words", xfer_words_o, 32'd0);

    // reset mid-frame, then restart from zero
    start_xfer("mrst", 6, 1, 0);
    cyc(0, 0, 0, NOD, 0, 0, 1);
    cyc(0, 0, 1, dv(0, 0, 0), 0, 0, 1);
    cyc(0, 0, 1, dv(0, 1, 1), 0, 0, 1);
    cyc(0, 0, 1, dv(0, 2, 2), 0, 0, 1);
    #1 dma_rstn = 1'b0;
    #1;
    check_val("mrst wren", 32'(W_wren_o), 32'd0);
    check_val("mrst data", W_data_o, 32'd0);
    check_val("mrst busy", 32'(busy_o), 32'd0);
    check_val("mrst frame_done", 32'(frame_done_o), 32'd0);
    check_val("mrst done", 32'(done_o), 32'd0);
    check_val("mrst xfer_words", xfer_words_o, 32'd0);
    @(posedge pl_clk); #2;
    dma_rstn = 1'b1;
    start_xfer("restart", 2, 1, 0);
    cyc(0, 0, 0, NOD, 0, 0, 1);
    cyc(0, 0, 1, dv(0, 0, 0), 0, 0, 1);
    cyc(0, 0, 1, dv(0, 1, 1), 1, 0, 1);
    cyc(0, 0, 0, NOD, 0, 1, 1);
    cyc(0, 0, 0, NOD, 0, 0, 0);
    check_val("restart xfer_words", xfer_words_o, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
